// File: rtl/piezo_fire_scheduler.sv
// Piezo burst scheduler: armed over Avalon-MM, fires on a PTP time match or an
// external trigger edge, then drives T_ON/T_OFF pulses on the channel mask.
module piezo_fire_scheduler #(
    parameter int NUM_CH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic [31:0]       time_now,
    input  logic              event_trigger,
    output logic [NUM_CH-1:0] piezo_out,
    output logic              piezo_enable,
    output logic [2:0]        status,
    output logic              irq
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_ON    = 3'd2,
        S_OFF   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [31:0]         r_target;
    logic [15:0]         r_t_on;
    logic [15:0]         r_t_off;
    logic [7:0]          r_count;
    logic [NUM_CH-1:0]   r_mask;
    logic [7:0]          r_fired;
    logic [31:0]         r_fire_ts;
    logic                r_irq;
    logic [NUM_CH-1:0]   r_piezo_out;
    logic                r_piezo_en;
    logic [15:0]         r_cnt;
    logic                r_time_reached;
    logic [31:0]         r_time_d;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_sync3;
    logic                r_trig_rise;
    logic [31:0]         r_readdata;

    logic                w_cfg_open;
    logic                w_ctrl_wr;
    logic                w_arm;
    logic                w_abort;
    logic                w_fire;
    logic                w_time_past;
    logic [15:0]         w_ton_m1;
    logic [15:0]         w_toff_m1;
    logic [7:0]          w_fired_inc;
    logic [31:0]         w_mask_rd;
    logic [31:0]         w_rd_mux;

    assign w_cfg_open  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_ctrl_wr   = avs_write && (avs_address == 3'd0);
    assign w_arm       = w_ctrl_wr && avs_writedata[0];
    assign w_abort     = w_ctrl_wr && avs_writedata[1];
    // Signed difference keeps the compare correct across time_now wrap.
    assign w_time_past = ($signed(time_now - r_target) >= 0);
    assign w_fire      = (r_state == S_ARMED) && (r_mode ? r_trig_rise : r_time_reached);
    assign w_ton_m1    = (r_t_on  == 16'd0) ? 16'd0 : r_t_on  - 16'd1;
    assign w_toff_m1   = (r_t_off == 16'd0) ? 16'd0 : r_t_off - 16'd1;
    assign w_fired_inc = (r_fired == 8'd255) ? 8'd255 : r_fired + 8'd1;

    always_comb begin
        w_mask_rd = '0;
        w_mask_rd[NUM_CH-1:0] = r_mask;
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            3'd0: w_rd_mux = {29'd0, r_mode, 2'b00};
            3'd1: w_rd_mux = r_target;
            3'd2: w_rd_mux = {16'd0, r_t_on};
            3'd3: w_rd_mux = {16'd0, r_t_off};
            3'd4: w_rd_mux = {24'd0, r_count};
            3'd5: w_rd_mux = w_mask_rd;
            3'd6: w_rd_mux = {15'd0, r_irq, r_fired, 5'd0, r_state};
            3'd7: w_rd_mux = r_fire_ts;
            default: w_rd_mux = '0;
        endcase
    end

    // Configuration is frozen while a burst is pending or running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= 1'b0;
            r_target <= '0;
            r_t_on   <= '0;
            r_t_off  <= '0;
            r_count  <= '0;
            r_mask   <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_mode <= avs_writedata[2];
            end
            if (avs_write && w_cfg_open) begin
                case (avs_address)
                    3'd1: r_target <= avs_writedata;
                    3'd2: r_t_on   <= avs_writedata[15:0];
                    3'd3: r_t_off  <= avs_writedata[15:0];
                    3'd4: r_count  <= avs_writedata[7:0];
                    3'd5: r_mask   <= avs_writedata[NUM_CH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Trigger synchronizer, edge detect and registered time compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1        <= 1'b0;
            r_sync2        <= 1'b0;
            r_sync3        <= 1'b0;
            r_trig_rise    <= 1'b0;
            r_time_reached <= 1'b0;
            r_time_d       <= '0;
        end else begin
            r_sync1        <= event_trigger;
            r_sync2        <= r_sync1;
            r_sync3        <= r_sync2;
            r_trig_rise    <= r_sync2 && !r_sync3;
            r_time_reached <= (r_state == S_ARMED) && w_time_past;
            r_time_d       <= time_now;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_piezo_out <= '0;
            r_piezo_en  <= 1'b0;
            r_irq       <= 1'b0;
            r_cnt       <= '0;
            r_fired     <= '0;
            r_fire_ts   <= '0;
        end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_piezo_out <= '0;
            r_piezo_en  <= 1'b0;
        end else begin
            if (avs_write && (avs_address == 3'd6)) begin
                r_irq <= 1'b0;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_arm) begin
                        r_state <= S_ARMED;
                        r_fired <= '0;
                    end
                end
                S_ARMED: begin
                    if (w_fire) begin
                        if (r_count == 8'd0) begin
                            r_state <= S_DONE;
                            r_irq   <= 1'b1;
                        end else begin
                            r_state     <= S_ON;
                            r_piezo_out <= r_mask;
                            r_piezo_en  <= 1'b1;
                            r_cnt       <= w_ton_m1;
                            r_fired     <= w_fired_inc;
                            // Time of the compare that caused the fire.
                            r_fire_ts   <= r_time_d;
                        end
                    end
                end
                S_ON: begin
                    if (r_cnt == 16'd0) begin
                        r_state     <= S_OFF;
                        r_piezo_out <= '0;
                        r_cnt       <= w_toff_m1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_OFF: begin
                    if (r_cnt == 16'd0) begin
                        if (r_fired < r_count) begin
                            r_state     <= S_ON;
                            r_piezo_out <= r_mask;
                            r_cnt       <= w_ton_m1;
                            r_fired     <= w_fired_inc;
                        end else begin
                            r_state    <= S_DONE;
                            r_piezo_en <= 1'b0;
                            r_irq      <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avs_readdata = r_readdata;
    assign piezo_out    = r_piezo_out;
    assign piezo_enable = r_piezo_en;
    assign status       = r_state;
    assign irq          = r_irq;

endmodule

// File: tb/tb_piezo_fire_scheduler.sv
// Self-checking bench for piezo_fire_scheduler: randomized bursts compared
// against a cycle-index waveform model of the pulse train.
module tb_piezo_fire_scheduler;
    localparam int NUM_CH = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        avs_address;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic [31:0]       time_now;
    logic              event_trigger;
    logic [NUM_CH-1:0] piezo_out;
    logic              piezo_enable;
    logic [2:0]        status;
    logic              irq;

    int checks = 0;
    int errors = 0;
    bit time_run = 1'b0;

    always #5 clk = ~clk;

    piezo_fire_scheduler #(.NUM_CH(NUM_CH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .time_now     (time_now),
        .event_trigger(event_trigger),
        .piezo_out    (piezo_out),
        .piezo_enable (piezo_enable),
        .status       (status),
        .irq          (irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: outputs are sampled 1 ns after the edge, and the PTP time advances then.
    task automatic tick();
        @(posedge clk);
        #1;
        if (time_run) time_now = time_now + 32'd1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        d           = avs_readdata;
        avs_read    = 1'b0;
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Expected output k cycles after the first pulse starts.
    function automatic logic [7:0] model_out(input int k, input int ton, input int toff,
                                             input int cnt, input logic [7:0] mask);
        int period;
        period = eff(ton) + eff(toff);
        if (k >= cnt * period) return 8'h00;
        return ((k % period) < eff(ton)) ? mask : 8'h00;
    endfunction

    task automatic cfg(input int ton, input int toff, input int cnt, input logic [7:0] mask);
        bus_write(3'd2, 32'(ton));
        bus_write(3'd3, 32'(toff));
        bus_write(3'd4, 32'(cnt));
        bus_write(3'd5, {24'd0, mask});
    endtask

    task automatic clear_irq(input string tag);
        bus_write(3'd6, 32'd0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL %s_irq_clear: irq=%0b expected 0", tag, irq);
        end
    endtask

    // Assumes ARMED in timed mode with target tgt still ahead; checks the whole burst.
    task automatic check_burst(input logic [31:0] tgt, input int ton, input int toff,
                               input int cnt, input logic [7:0] mask, input string tag);
        int total;
        int i;
        bit early;
        logic [31:0] rd;
        logic [7:0] exp_o;
        logic exp_en;
        total = cnt * (eff(ton) + eff(toff));
        early = 1'b0;
        i = 0;
        while (time_now != tgt && i < 300) begin
            if (piezo_out !== 8'h00 || piezo_enable !== 1'b0 || status !== 3'd1) early = 1'b1;
            tick();
            i++;
        end
        checks++;
        if (time_now !== tgt) begin
            errors++;
            $display("FAIL %s_wait_target: time_now=%0h expected %0h", tag, time_now, tgt);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL %s_early_fire: output active before target %0h", tag, tgt);
        end
        tick();
        checks++;
        if (piezo_out !== 8'h00) begin
            errors++;
            $display("FAIL %s_latency1: piezo_out=%0h expected 0", tag, piezo_out);
        end
        tick();
        for (int k = 0; k <= total; k++) begin
            exp_o  = model_out(k, ton, toff, cnt, mask);
            exp_en = (k < total);
            checks++;
            if (piezo_out !== exp_o || piezo_enable !== exp_en) begin
                errors++;
                $display("FAIL %s_wave[%0d]: out=%0h en=%0b expected out=%0h en=%0b",
                         tag, k, piezo_out, piezo_enable, exp_o, exp_en);
            end
            if (k < total) tick();
        end
        checks++;
        if (irq !== 1'b1 || status !== 3'd4) begin
            errors++;
            $display("FAIL %s_done: irq=%0b status=%0d expected irq=1 status=4", tag, irq, status);
        end
        bus_read(3'd6, rd);
        checks++;
        if (rd[15:8] !== 8'(cnt) || rd[16] !== 1'b1 || rd[2:0] !== 3'd4) begin
            errors++;
            $display("FAIL %s_status_reg: got %0h expected fired=%0d irq=1 state=4", tag, rd, cnt);
        end
        bus_read(3'd7, rd);
        checks++;
        if (rd !== tgt) begin
            errors++;
            $display("FAIL %s_fire_ts: got %0h expected %0h", tag, rd, tgt);
        end
        clear_irq(tag);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        event_trigger = 1'b0;
        time_now      = $urandom;
        repeat (3) tick();
        checks++;
        if (piezo_out !== 8'h00 || piezo_enable !== 1'b0 || irq !== 1'b0 ||
            status !== 3'd0 || avs_readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: out=%0h en=%0b irq=%0b st=%0d rd=%0h expected all 0",
                     piezo_out, piezo_enable, irq, status, avs_readdata);
        end
        reset_n  = 1'b1;
        time_run = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %0h expected 0", a, rd);
            end
        end
    endtask

    task automatic test_timed_burst();
        int ton, toff, cnt;
        logic [7:0] mask;
        logic [31:0] tgt;
        cfg(3, 2, 2, 8'h05);
        time_now = 32'd990;
        bus_write(3'd1, 32'd1000);
        bus_write(3'd0, 32'h1);
        check_burst(32'd1000, 3, 2, 2, 8'h05, "timed_fixed");
        for (int r = 0; r < 5; r++) begin
            ton  = $urandom_range(0, 4);
            toff = $urandom_range(0, 4);
            cnt  = $urandom_range(1, 4);
            mask = 8'($urandom_range(1, 255));
            cfg(ton, toff, cnt, mask);
            tgt = time_now + 32'($urandom_range(8, 30));
            bus_write(3'd1, tgt);
            bus_write(3'd0, 32'h1);
            check_burst(tgt, ton, toff, cnt, mask, $sformatf("timed_rand%0d", r));
        end
    endtask

    task automatic test_wrap();
        cfg(1, 1, 1, 8'hA0);
        time_now = 32'hFFFF_FFEE;
        bus_write(3'd1, 32'h0000_0005);
        bus_write(3'd0, 32'h1);
        check_burst(32'h0000_0005, 1, 1, 1, 8'hA0, "wrap");
    endtask

    task automatic test_past_target();
        logic [7:0] mask;
        mask = 8'($urandom_range(1, 255));
        cfg(1, 1, 1, mask);
        bus_write(3'd1, time_now - 32'd50);
        bus_write(3'd0, 32'h1);
        checks++;
        if (status !== 3'd1 || piezo_out !== 8'h00) begin
            errors++;
            $display("FAIL past_armed: st=%0d out=%0h expected st=1 out=0", status, piezo_out);
        end
        tick();
        checks++;
        if (piezo_out !== 8'h00) begin
            errors++;
            $display("FAIL past_latency1: out=%0h expected 0", piezo_out);
        end
        tick();
        checks++;
        if (piezo_out !== mask) begin
            errors++;
            $display("FAIL past_fire: out=%0h expected %0h", piezo_out, mask);
        end
        repeat (2) tick();
        checks++;
        if (status !== 3'd4 || irq !== 1'b1) begin
            errors++;
            $display("FAIL past_done: st=%0d irq=%0b expected st=4 irq=1", status, irq);
        end
        clear_irq("past");
    endtask

    task automatic test_trigger();
        logic [7:0] mask;
        bit moved;
        mask = 8'($urandom_range(1, 255));
        cfg(1, 1, 1, mask);
        bus_write(3'd0, 32'h5);
        repeat ($urandom_range(1, 5)) tick();
        checks++;
        if (status !== 3'd1) begin
            errors++;
            $display("FAIL trig_armed: st=%0d expected 1", status);
        end
        event_trigger = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (piezo_out !== 8'h00) begin
                errors++;
                $display("FAIL trig_early%0d: out=%0h expected 0", c, piezo_out);
            end
        end
        tick();
        checks++;
        if (piezo_out !== mask || piezo_enable !== 1'b1) begin
            errors++;
            $display("FAIL trig_fire: out=%0h en=%0b expected out=%0h en=1", piezo_out, piezo_enable, mask);
        end
        tick();
        checks++;
        if (piezo_out !== 8'h00 || piezo_enable !== 1'b1) begin
            errors++;
            $display("FAIL trig_gap: out=%0h en=%0b expected out=0 en=1", piezo_out, piezo_enable);
        end
        tick();
        checks++;
        if (status !== 3'd4 || irq !== 1'b1 || piezo_enable !== 1'b0) begin
            errors++;
            $display("FAIL trig_done: st=%0d irq=%0b en=%0b expected 4/1/0", status, irq, piezo_enable);
        end
        event_trigger = 1'b0;
        repeat (3) tick();
        event_trigger = 1'b1;
        moved = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (piezo_out !== 8'h00 || status !== 3'd4) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL trig_done_ignore: out=%0h st=%0d expected out=0 st=4", piezo_out, status);
        end
        event_trigger = 1'b0;
        clear_irq("trig");
    endtask

    task automatic test_abort();
        logic [7:0] mask;
        logic [31:0] tgt;
        mask = 8'($urandom_range(1, 255));
        cfg(10, 2, 3, mask);
        tgt = time_now + 32'd10;
        bus_write(3'd1, tgt);
        bus_write(3'd0, 32'h1);
        while (time_now != tgt) tick();
        repeat (2) tick();
        repeat (3) tick();
        checks++;
        if (piezo_out !== mask || status !== 3'd2) begin
            errors++;
            $display("FAIL abort_pre: out=%0h st=%0d expected out=%0h st=2", piezo_out, status, mask);
        end
        bus_write(3'd0, 32'h3);
        checks++;
        if (piezo_out !== 8'h00 || piezo_enable !== 1'b0 || status !== 3'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL abort_post: out=%0h en=%0b st=%0d irq=%0b expected 0/0/0/0",
                     piezo_out, piezo_enable, status, irq);
        end
    endtask

    task automatic test_count_zero();
        logic [31:0] tgt;
        logic [31:0] rd;
        bit en_seen;
        int i;
        cfg(2, 2, 0, 8'hFF);
        tgt = time_now + 32'd20;
        bus_write(3'd1, tgt);
        bus_write(3'd0, 32'h1);
        bus_write(3'd1, ~tgt);
        bus_read(3'd1, rd);
        checks++;
        if (rd !== tgt) begin
            errors++;
            $display("FAIL cnt0_target_locked: got %0h expected %0h", rd, tgt);
        end
        en_seen = 1'b0;
        i = 0;
        while (status !== 3'd4 && i < 60) begin
            if (piezo_enable !== 1'b0 || piezo_out !== 8'h00) en_seen = 1'b1;
            tick();
            i++;
        end
        checks++;
        if (status !== 3'd4 || irq !== 1'b1 || en_seen) begin
            errors++;
            $display("FAIL cnt0_done: st=%0d irq=%0b en_seen=%0b expected 4/1/0", status, irq, en_seen);
        end
        bus_read(3'd6, rd);
        checks++;
        if (rd[15:8] !== 8'd0) begin
            errors++;
            $display("FAIL cnt0_fired: got %0d expected 0", rd[15:8]);
        end
        clear_irq("cnt0");
    endtask

    task automatic test_count_max();
        logic [31:0] rd;
        logic [7:0] prev;
        int high_cycles;
        int pulses;
        int i;
        cfg(1, 1, 255, 8'h3C);
        bus_write(3'd1, time_now - 32'd100);
        bus_write(3'd0, 32'h1);
        high_cycles = 0;
        pulses = 0;
        prev = 8'h00;
        i = 0;
        while (status !== 3'd4 && i < 700) begin
            tick();
            if (piezo_enable === 1'b1) high_cycles++;
            if (prev === 8'h00 && piezo_out === 8'h3C) pulses++;
            prev = piezo_out;
            i++;
        end
        checks++;
        if (status !== 3'd4 || high_cycles != 510 || pulses != 255) begin
            errors++;
            $display("FAIL cntmax_burst: st=%0d en_cycles=%0d pulses=%0d expected 4/510/255",
                     status, high_cycles, pulses);
        end
        bus_read(3'd6, rd);
        checks++;
        if (rd[15:8] !== 8'd255) begin
            errors++;
            $display("FAIL cntmax_fired: got %0d expected 255", rd[15:8]);
        end
        clear_irq("cntmax");
    endtask

    task automatic test_reset_in_off();
        logic [31:0] tgt;
        logic [31:0] rd;
        cfg(2, 8, 2, 8'h81);
        tgt = time_now + 32'd10;
        bus_write(3'd1, tgt);
        bus_write(3'd0, 32'h1);
        while (time_now != tgt) tick();
        repeat (4) tick();
        checks++;
        if (status !== 3'd3 || piezo_enable !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: st=%0d en=%0b expected st=3 en=1", status, piezo_enable);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (piezo_out !== 8'h00 || piezo_enable !== 1'b0 || status !== 3'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: out=%0h en=%0b st=%0d irq=%0b expected all 0",
                     piezo_out, piezo_enable, status, irq);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        for (int a = 1; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL rst_reg%0d: got %0h expected 0", a, rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timed_burst();
        test_wrap();
        test_past_target();
        test_trigger();
        test_abort();
        test_count_zero();
        test_count_max();
        test_reset_in_off();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
